sram_like_arbiter: RTL and testbench

//  Shares one downstream sram-like port between the IF-stage instruction port and
//  the MEM-stage data port. Arbitrates requests, holds the grant across addrok

---
 rtl/sram_like_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Two-to-one sram-like port arbiter: IF and MEM requests share one downstream port.
// Optional ARB_ROUND_ROBIN_EN macro swaps fixed data-first priority for alternating grants.
module sram_like_arbiter #(
  parameter int OUTSTANDING = 4,
  parameter int ID_W        = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addrok,
  output logic        inst_dataok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addrok,
  output logic        data_dataok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic        m_addrok,
  input  logic        m_dataok,
  input  logic [31:0] m_rdata
);

  logic            lock_valid_r;
  logic            lock_id_r;
  logic            id_q_r [OUTSTANDING];
  logic [ID_W-1:0] wptr_r;
  logic [ID_W-1:0] rptr_r;
  logic [ID_W:0]   cnt_r;

  logic full_s;
  logic winner_s;
  logic grant_s;
  logic granted_req_s;
  logic accept_s;
  logic resp_s;
  logic head_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_r;

  // Remember the last accepted source so contested cycles alternate
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant_r <= 1'b0;
    end else if (accept_s) begin
      last_grant_r <= grant_s;
    end
  end

  // Round-robin winner: alternate when both request, otherwise whoever asks
  always_comb begin
    winner_s = 1'b0;
    if (inst_req && data_req) begin
      winner_s = ~last_grant_r;
    end else begin
      winner_s = data_req;
    end
  end
`else
  // Fixed priority winner: the MEM stage always beats the IF stage
  always_comb begin
    winner_s = 1'b0;
    if (data_req) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
  end
`endif

  // Grant selection, downstream request and handshake decode
  always_comb begin
    full_s        = (cnt_r == (ID_W+1)'(OUTSTANDING));
    grant_s       = lock_valid_r ? lock_id_r : winner_s;
    granted_req_s = grant_s ? data_req : inst_req;
    m_req         = resetn & ~full_s & granted_req_s;
    accept_s      = m_req & m_addrok;
    head_s        = id_q_r[rptr_r];
    resp_s        = resetn & m_dataok & (cnt_r != {(ID_W+1){1'b0}});
  end

  // Payload mux and response routing; everything forced low while in reset
  always_comb begin
    m_wr        = 1'b0;
    m_size      = 2'b00;
    m_addr      = 32'h0000_0000;
    m_wstrb     = 4'h0;
    m_wdata     = 32'h0000_0000;
    inst_rdata  = 32'h0000_0000;
    data_rdata  = 32'h0000_0000;
    inst_addrok = accept_s & ~grant_s;
    data_addrok = accept_s & grant_s;
    inst_dataok = resp_s & ~head_s;
    data_dataok = resp_s & head_s;
    if (!resetn) begin
      m_wr = 1'b0;
    end else if (grant_s) begin
      m_wr    = data_wr;
      m_size  = data_size;
      m_addr  = data_addr;
      m_wstrb = data_wstrb;
      m_wdata = data_wdata;
    end else begin
      m_wr    = inst_wr;
      m_size  = inst_size;
      m_addr  = inst_addr;
      m_wstrb = inst_wstrb;
      m_wdata = inst_wdata;
    end
    if (resetn) begin
      inst_rdata = m_rdata;
      data_rdata = m_rdata;
    end else begin
      inst_rdata = 32'h0000_0000;
      data_rdata = 32'h0000_0000;
    end
  end

  // Hold the grant across addrok stalls so the presented request never changes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_valid_r <= 1'b0;
      lock_id_r    <= 1'b0;
    end else if (m_req && !m_addrok) begin
      lock_valid_r <= 1'b1;
      lock_id_r    <= grant_s;
    end else if (m_addrok) begin
      lock_valid_r <= 1'b0;
    end
  end

  // In-order ID FIFO: source of each accepted request, popped by m_dataok
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        id_q_r[i] <= 1'b0;
      end
      wptr_r <= {ID_W{1'b0}};
      rptr_r <= {ID_W{1'b0}};
      cnt_r  <= {(ID_W+1){1'b0}};
    end else begin
      if (accept_s) begin
        id_q_r[wptr_r] <= grant_s;
        wptr_r         <= wptr_r + {{(ID_W-1){1'b0}}, 1'b1};
      end
      if (resp_s) begin
        rptr_r <= rptr_r + {{(ID_W-1){1'b0}}, 1'b1};
      end
      case ({accept_s, resp_s})
        2'b10:   cnt_r <= cnt_r + {{ID_W{1'b0}}, 1'b1};
        2'b01:   cnt_r <= cnt_r - {{ID_W{1'b0}}, 1'b1};
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: routing, stall lock, FIFO limit, wrap, reset.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addrok, inst_dataok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addrok, data_dataok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_addrok, m_dataok;
  logic [31:0] m_rdata;

  int total = 0;
  int fails = 0;

  sram_like_arbiter #(.OUTSTANDING(4), .ID_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addrok(inst_addrok),
    .inst_dataok(inst_dataok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addrok(data_addrok),
    .data_dataok(data_dataok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb),
    .m_wdata(m_wdata), .m_addrok(m_addrok), .m_dataok(m_dataok), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req = 1'b0; data_req = 1'b0; m_addrok = 1'b0; m_dataok = 1'b0;
  endtask

  initial begin
    logic rr;
    logic prev_g;
    logic exp_g;
`ifdef ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    resetn = 1'b0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hbfc0_0000;
    inst_wstrb = 4'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0;
    data_wstrb = 4'h0; data_wdata = 32'h0;
    m_addrok = 1'b1; m_dataok = 1'b1; m_rdata = 32'hdead_beef;
    #2;
    chk("rst_m_req", m_req, 32'd0);
    chk("rst_inst_addrok", inst_addrok, 32'd0);
    chk("rst_inst_dataok", inst_dataok, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_cnt", dut.cnt_r, 32'd0);
    cyc(); cyc();
    idle();
    resetn = 1'b1;
    cyc();

    // 1: single instruction fetch
    inst_req = 1'b1; inst_addr = 32'hbfc0_0000; m_addrok = 1'b1; #2;
    chk("t1_m_req", m_req, 32'd1);
    chk("t1_m_addr", m_addr, 32'hbfc0_0000);
    chk("t1_inst_addrok", inst_addrok, 32'd1);
    chk("t1_data_addrok", data_addrok, 32'd0);
    cyc();
    idle(); m_dataok = 1'b1; m_rdata = 32'h3c08_bfaf; #2;
    chk("t1_inst_dataok", inst_dataok, 32'd1);
    chk("t1_data_dataok", data_dataok, 32'd0);
    chk("t1_inst_rdata", inst_rdata, 32'h3c08_bfaf);
    cyc();
    idle(); #2;
    chk("t1_cnt", dut.cnt_r, 32'd0);

    // 2: contention with a three-cycle stall
    inst_req = 1'b1; inst_addr = 32'h0000_1000;
    data_req = 1'b1; data_addr = 32'h0000_2000; data_wr = 1'b1;
    data_wstrb = 4'hf; data_wdata = 32'h1234_5678; m_addrok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("t2_stall_m_addr", m_addr, 32'h0000_2000);
      chk("t2_stall_inst_addrok", inst_addrok, 32'd0);
      chk("t2_stall_data_addrok", data_addrok, 32'd0);
      cyc();
    end
    chk("t2_lock_valid", dut.lock_valid_r, 32'd1);
    chk("t2_m_wr", m_wr, 32'd1);
    chk("t2_m_wstrb", m_wstrb, 32'hf);
    chk("t2_m_wdata", m_wdata, 32'h1234_5678);
    m_addrok = 1'b1; #2;
    chk("t2_m_addr", m_addr, 32'h0000_2000);
    chk("t2_data_addrok", data_addrok, 32'd1);
    chk("t2_inst_addrok", inst_addrok, 32'd0);
    cyc();
    data_req = 1'b0; data_wr = 1'b0; #2;
    chk("t2_inst_m_addr", m_addr, 32'h0000_1000);
    chk("t2_inst_addrok", inst_addrok, 32'd1);
    cyc();
    idle(); m_dataok = 1'b1; #2;
    chk("t2_resp0_data", data_dataok, 32'd1);
    chk("t2_resp0_inst", inst_dataok, 32'd0);
    cyc();
    #2;
    chk("t2_resp1_inst", inst_dataok, 32'd1);
    chk("t2_resp1_data", data_dataok, 32'd0);
    cyc();

    // 2b: a stalled inst grant is not stolen by a late data request
    idle(); inst_req = 1'b1; inst_addr = 32'h0000_3000; #2;
    cyc();
    data_req = 1'b1; data_addr = 32'h0000_4000; #2;
    chk("t2b_locked_addr", m_addr, 32'h0000_3000);
    m_addrok = 1'b1; #2;
    chk("t2b_inst_addrok", inst_addrok, 32'd1);
    chk("t2b_data_addrok", data_addrok, 32'd0);
    cyc();
    inst_req = 1'b0; #2;
    chk("t2b_data_addrok2", data_addrok, 32'd1);
    cyc();
    idle(); m_dataok = 1'b1; #2;
    chk("t2b_resp0", {30'd0, inst_dataok, data_dataok}, 32'd2);
    cyc(); #2;
    chk("t2b_resp1", {30'd0, inst_dataok, data_dataok}, 32'd1);
    cyc();

    // 3: outstanding limit
    idle(); inst_req = 1'b1; inst_addr = 32'h0000_5000; m_addrok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t3_fill_addrok", inst_addrok, 32'd1);
      cyc();
    end
    chk("t3_cnt_full", dut.cnt_r, 32'd4);
    m_dataok = 1'b1; #2;
    chk("t3_full_m_req", m_req, 32'd0);
    chk("t3_full_addrok", inst_addrok, 32'd0);
    chk("t3_full_dataok", inst_dataok, 32'd1);
    cyc();
    m_dataok = 1'b0; #2;
    chk("t3_cnt3", dut.cnt_r, 32'd3);
    chk("t3_m_req_again", m_req, 32'd1);
    cyc();
    chk("t3_cnt_refull", dut.cnt_r, 32'd4);
    idle(); m_dataok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("t3_drain_inst", inst_dataok, 32'd1);
      cyc();
    end
    idle(); #2;
    chk("t3_cnt_empty", dut.cnt_r, 32'd0);

    // 4: alternating sources with pointer wrap and overlapped accept/response
    for (int k = 0; k <= 8; k++) begin
      inst_req = (k < 8) && (k % 2 == 0);
      data_req = (k < 8) && (k % 2 == 1);
      inst_addr = 32'h0000_6000 + 32'(k);
      data_addr = 32'h0000_7000 + 32'(k);
      m_addrok = (k < 8);
      m_dataok = (k >= 1);
      m_rdata = 32'h0000_0a00 + 32'(k);
      #2;
      if (k < 8) begin
        chk("t4_inst_addrok", inst_addrok, 32'((k % 2) == 0));
        chk("t4_data_addrok", data_addrok, 32'((k % 2) == 1));
      end
      if (k >= 1) begin
        chk("t4_inst_dataok", inst_dataok, 32'(((k - 1) % 2) == 0));
        chk("t4_data_dataok", data_dataok, 32'(((k - 1) % 2) == 1));
        chk("t4_rdata", data_rdata, 32'h0000_0a00 + 32'(k));
      end
      cyc();
    end
    idle(); #2;
    chk("t4_cnt", dut.cnt_r, 32'd0);

    // 5: stray response and reset mid-operation
    m_dataok = 1'b1; #2;
    chk("t5_stray", {30'd0, inst_dataok, data_dataok}, 32'd0);
    cyc();
    chk("t5_stray_cnt", dut.cnt_r, 32'd0);
    idle(); inst_req = 1'b1; m_addrok = 1'b1;
    cyc(); cyc();
    m_addrok = 1'b0;
    cyc();
    chk("t5_pre_cnt", dut.cnt_r, 32'd2);
    chk("t5_pre_lock", dut.lock_valid_r, 32'd1);
    m_dataok = 1'b1;
    resetn = 1'b0; #1;
    chk("t5_rst_cnt", dut.cnt_r, 32'd0);
    chk("t5_rst_lock", dut.lock_valid_r, 32'd0);
    chk("t5_rst_m_req", m_req, 32'd0);
    chk("t5_rst_dataok", inst_dataok, 32'd0);
    cyc();
    idle(); resetn = 1'b1; m_dataok = 1'b1; #2;
    chk("t5_post_stray", {30'd0, inst_dataok, data_dataok}, 32'd0);
    cyc();

    // 6: continuous contention (alternates only with round robin)
    idle(); inst_req = 1'b1; data_req = 1'b1; m_addrok = 1'b1;
    inst_addr = 32'h0000_8000; data_addr = 32'h0000_9000;
    prev_g = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_dataok = (k >= 1);
      exp_g = rr ? ~prev_g : 1'b1;
      #2;
      chk("t6_data_addrok", data_addrok, 32'(exp_g));
      chk("t6_inst_addrok", inst_addrok, 32'(!exp_g));
      if (k >= 1) begin
        chk("t6_dataok", {30'd0, inst_dataok, data_dataok}, prev_g ? 32'd1 : 32'd2);
      end
      prev_g = exp_g;
      cyc();
    end
    idle(); m_dataok = 1'b1; #2;
    chk("t6_last_dataok", {30'd0, inst_dataok, data_dataok}, prev_g ? 32'd1 : 32'd2);
    cyc();
    idle(); #2;
    chk("t6_cnt", dut.cnt_r, 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
